// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size
// codes, the responder FSM state type and a store-data replication helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  // Spread right-aligned store data across every lane it could land in, so
  // the byte enables alone decide which lanes actually change.
  function automatic logic [31:0] lane_replicate(input logic [2:0] funct3,
                                                 input logic [31:0] wdata);
    logic [31:0] rep;
    case (funct3)
      F3_B:    rep = {4{wdata[7:0]}};
      F3_H:    rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: decodes size/sign and the low address bits
// into byte enables, a merged store word, extended load data and an error.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be_raw;
  logic [31:0] ld_raw;
  logic [31:0] rep_data;

  assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = old_word[{addr_lo[1], 4'b0000} +: 16];
  assign rep_data = lane_replicate(funct3, wdata);

  // Size/sign decode: raw lane mask, raw extended load value and legality.
  always_comb begin
    be_raw = 4'b0000;
    ld_raw = 32'h0;
    err    = 1'b0;
    case (funct3)
      F3_B: begin
        be_raw = 4'b0001 << addr_lo;
        ld_raw = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        err    = we;
        ld_raw = {24'h0, byte_sel};
      end
      F3_H: begin
        err    = addr_lo[0];
        be_raw = addr_lo[1] ? 4'b1100 : 4'b0011;
        ld_raw = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        err    = addr_lo[0] | we;
        ld_raw = {16'h0, half_sel};
      end
      F3_W: begin
        err    = (addr_lo != 2'b00);
        be_raw = 4'b1111;
        ld_raw = old_word;
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  // Gate by direction and error, then merge the new lanes over the old word.
  always_comb begin
    byte_en    = (we && !err) ? be_raw : 4'b0000;
    load_data  = (!we && !err) ? ld_raw : 32'h0;
    store_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (byte_en[i]) begin
        store_word[8*i +: 8] = rep_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: one request per valid/ready handshake, a
// programmable wait, a single-cycle array access and a held response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int         WORDS   = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem_q [0:WORDS-1];
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] fmt_load;
  logic [3:0]        fmt_be;
  logic              fmt_err;
  logic              mem_we;

  assign old_word = mem_q[addr_q[DM_ADDRESS-1:2]];

  dmem_lane_fmt u_fmt (
    .we         (we_q),
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .old_word   (old_word),
    .wdata      (wdata_q),
    .store_word (store_word),
    .byte_en    (fmt_be),
    .load_data  (fmt_load),
    .err        (fmt_err)
  );

  // Next-state, counter, request capture and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_CNT;
          // A zero count still spends one cycle in WAIT so the response
          // always appears LATENCY+2 cycles after the accept edge.
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        // The only cycle that touches the array, so a store commits once.
        mem_we      = (fmt_be != 4'b0000);
        rsp_rdata_d = fmt_load;
        rsp_err_d   = fmt_err;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers; reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request payload latches; only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q[DM_ADDRESS-1:2]] <= store_word;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance and a
// LATENCY=0 instance share stimulus, selected by sel, and are checked
// against a byte-addressed reference memory.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [31:0] rd2, rd0;

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;
  assign req_ready_m = sel ? rr0 : rr2;
  assign rsp_valid_m = sel ? rv0 : rv2;
  assign rsp_err_m   = sel ? re0 : re2;
  assign rsp_rdata_m = sel ? rd0 : rd2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [2][512];

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid & ~sel),
    .req_ready  (rr2),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rv2),
    .rsp_ready  (rsp_ready & ~sel),
    .rsp_rdata  (rd2),
    .rsp_err    (re2)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid & sel),
    .req_ready  (rr0),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rv0),
    .rsp_ready  (rsp_ready & sel),
    .rsp_rdata  (rd0),
    .rsp_err    (re0)
  );

  // Reference: byte memory, access size from funct3, alignment by modulo.
  function automatic void model(input bit s, input bit we, input logic [2:0] f3,
                                input logic [8:0] a, input logic [31:0] wd,
                                output logic [31:0] erd, output bit eer);
    int size;
    logic [31:0] v, mask;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    if (size == 0) eer = 1'b1;
    else eer = (we && f3[2]) || ((int'(a) % size) != 0);
    erd = 32'h0;
    if (!eer) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[s][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mb[s][int'(a) + i]) << (8*i));
        if (size < 4 && !f3[2]) begin
          mask = (32'd1 << (8*size)) - 32'd1;
          if (v[8*size-1]) v = v | ~mask;
        end
        erd = v;
      end
    end
  endfunction

  // One complete transaction; lat = cycles from accept edge to rsp_valid.
  task automatic txn(input bit s, input bit we, input logic [2:0] f3,
                     input logic [8:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output bit er, output int lat);
    int n;
    sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready_m && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL txn_ready_timeout: req_ready never rose");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid_m && lat < 60) begin @(posedge clk); #1; lat++; end
    if (lat >= 60) begin
      n_tests++; n_fail++;
      $display("FAIL txn_rsp_timeout: rsp_valid never rose");
    end
    rd = rsp_rdata_m;
    er = rsp_err_m;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (req_ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready_m); end
    n_tests++; if (rsp_valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_m); end
    n_tests++; if (rsp_rdata_m !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata_m); end
    n_tests++; if (rsp_err_m !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err_m); end
    n_tests++; if (rr0 !== 1'b1 || rv0 !== 1'b0) begin n_fail++; $display("FAIL reset_lat0: ready %b valid %b want 1 0", rr0, rv0); end
  endtask

  task automatic test_fill();
    logic [31:0] rd, mrd, wd; bit er, mer; int lat;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 128; w++) begin
        wd = $urandom;
        txn(s[0], 1'b1, F3_W, 9'(w*4), wd, rd, er, lat);
        model(s[0], 1'b1, F3_W, 9'(w*4), wd, mrd, mer);
        n_tests++;
        if (er !== 1'b0 || rd !== 32'h0) begin
          n_fail++; $display("FAIL fill_sw: word %0d err %b rdata %h want 0 0", w, er, rd);
        end
      end
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  task automatic test_lanes_and_errors();
    vec_t tbl [14];
    logic [31:0] rd, mrd; bit er, mer; int lat;
    tbl[0]  = '{1'b1, F3_W,   9'h004, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, F3_W,   9'h004, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, F3_B,   9'h005, 32'h000000A5, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, F3_W,   9'h004, 32'h0,        32'hDEADA5EF, 1'b0};
    tbl[4]  = '{1'b0, F3_B,   9'h005, 32'h0,        32'hFFFFFFA5, 1'b0};
    tbl[5]  = '{1'b0, F3_BU,  9'h005, 32'h0,        32'h000000A5, 1'b0};
    tbl[6]  = '{1'b1, F3_H,   9'h006, 32'h00008001, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, F3_H,   9'h006, 32'h0,        32'hFFFF8001, 1'b0};
    tbl[8]  = '{1'b0, F3_HU,  9'h006, 32'h0,        32'h00008001, 1'b0};
    tbl[9]  = '{1'b0, F3_W,   9'h004, 32'h0,        32'h8001A5EF, 1'b0};
    tbl[10] = '{1'b0, F3_W,   9'h002, 32'h0,        32'h00000000, 1'b1};
    tbl[11] = '{1'b1, F3_H,   9'h003, 32'h00001234, 32'h00000000, 1'b1};
    tbl[12] = '{1'b1, F3_BU,  9'h008, 32'h000000FF, 32'h00000000, 1'b1};
    tbl[13] = '{1'b0, 3'b011, 9'h008, 32'h0,        32'h00000000, 1'b1};
    for (int i = 0; i < 14; i++) begin
      txn(1'b0, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat);
      model(1'b0, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, mrd, mer);
      n_tests++;
      if (rd !== tbl[i].rd || er !== tbl[i].er) begin
        n_fail++; $display("FAIL directed_%0d: rdata %h err %b want %h %b", i, rd, er, tbl[i].rd, tbl[i].er);
      end
      n_tests++;
      if (lat != 4) begin n_fail++; $display("FAIL directed_lat_%0d: got %0d want 4", i, lat); end
    end
    model(1'b0, 1'b0, F3_W, 9'h000, 32'h0, mrd, mer);
    txn(1'b0, 1'b0, F3_W, 9'h000, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== mrd || er !== 1'b0) begin
      n_fail++; $display("FAIL word0_unchanged: rdata %h err %b want %h 0", rd, er, mrd);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_a, exp_b, rd; bit mer; int n;
    model(1'b0, 1'b0, F3_W, 9'h004, 32'h0, exp_a, mer);
    model(1'b0, 1'b0, F3_W, 9'h000, 32'h0, exp_b, mer);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W;
    req_addr = 9'h004; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_addr = 9'h000;
    n = 0;
    while (!rsp_valid_m && n < 60) begin @(posedge clk); #1; n++; end
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL stall_first_lat: got %0d want 4", n); end
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== exp_a || req_ready_m !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_%0d: valid %b rdata %h ready %b want 1 %h 0", c, rsp_valid_m, rsp_rdata_m, req_ready_m, exp_a);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid_m !== 1'b0 || req_ready_m !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: valid %b ready %b want 0 1", rsp_valid_m, req_ready_m);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (req_ready_m !== 1'b0) begin n_fail++; $display("FAIL stall_next_accept: ready %b want 0", req_ready_m); end
    n = 0;
    while (!rsp_valid_m && n < 60) begin @(posedge clk); #1; n++; end
    rd = rsp_rdata_m;
    n_tests++;
    if (n != 4 || rd !== exp_b) begin
      n_fail++; $display("FAIL stall_second_rsp: lat %0d rdata %h want 4 %h", n, rd, exp_b);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] exp, rd; bit er, mer; int lat;
    model(1'b0, 1'b0, F3_W, 9'h010, 32'h0, exp, mer);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 9'h010; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0 || rsp_rdata_m !== 32'h0 || rsp_err_m !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait_outputs: ready %b valid %b rdata %h err %b want 1 0 0 0", req_ready_m, rsp_valid_m, rsp_rdata_m, rsp_err_m);
    end
    txn(1'b0, 1'b0, F3_W, 9'h010, 32'h0, rd, er, lat);
    n_tests++;
    if (rd !== exp || er !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait_no_commit: rdata %h err %b want %h 0", rd, er, exp);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, mrd; bit er, mer; int lat;
    txn(1'b1, 1'b1, F3_W, 9'h004, 32'hDEADBEEF, rd, er, lat);
    model(1'b1, 1'b1, F3_W, 9'h004, 32'hDEADBEEF, mrd, mer);
    n_tests++;
    if (lat != 2 || er !== 1'b0) begin n_fail++; $display("FAIL lat0_sw: lat %0d err %b want 2 0", lat, er); end
    txn(1'b1, 1'b0, F3_W, 9'h004, 32'h0, rd, er, lat);
    model(1'b1, 1'b0, F3_W, 9'h004, 32'h0, mrd, mer);
    n_tests++;
    if (lat != 2 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat0_lw: lat %0d rdata %h want 2 deadbeef", lat, rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, wd; logic [2:0] f3; logic [8:0] a;
    bit er, mer, we, s; int lat;
    logic [2:0] legal [5];
    legal[0] = F3_B; legal[1] = F3_H; legal[2] = F3_W; legal[3] = F3_BU; legal[4] = F3_HU;
    for (int i = 0; i < 120; i++) begin
      s  = (i >= 80);
      we = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom);
      a  = 9'($urandom);
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b00) ? a[1:0] : ((f3[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00);
      wd = $urandom;
      txn(s, we, f3, a, wd, rd, er, lat);
      model(s, we, f3, a, wd, mrd, mer);
      n_tests++;
      if (rd !== mrd || er !== mer || lat != (s ? 2 : 4)) begin
        n_fail++; $display("FAIL random_%0d: we %b f3 %b addr %h rdata %h err %b lat %0d want %h %b %0d", i, we, f3, a, rd, er, lat, mrd, mer, s ? 2 : 4);
      end
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 9'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_fill();
    test_lanes_and_errors();
    test_stall();
    test_reset_in_wait();
    test_latency0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
